// File: rtl/delta_packer_if.sv
// delta_packer_if -- handshake and data bus of the delta packer.
//
// Groups the input vector handshake, the trace-buffer output handshake and
// the reference readback into one bundle.
//   valid_in / ready_out / vector_in       : input vector handshake
//   valid_out / ready_in / vector_out      : trace-buffer entry handshake
//   compression_flag_out / slots_used_out  : entry type and delta slot count
//   inc_tb_ptr                             : trace-buffer pointer increment
//   last_vector_out                        : current reference vector
// Modports: slave = packer side, master = producer/trace-buffer side.
interface delta_packer_if #(
  parameter int N           = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int DELTA_SLOTS = 2
);
  localparam int SW = $clog2(DELTA_SLOTS + 1);

  logic                         valid_in;
  logic                         ready_out;
  logic [N-1:0][DATA_WIDTH-1:0] vector_in;
  logic                         valid_out;
  logic                         ready_in;
  logic [N-1:0][DATA_WIDTH-1:0] vector_out;
  logic                         compression_flag_out;
  logic [SW-1:0]                slots_used_out;
  logic                         inc_tb_ptr;
  logic [N-1:0][DATA_WIDTH-1:0] last_vector_out;

  modport slave (
    input  valid_in, vector_in, ready_in,
    output ready_out, valid_out, vector_out, compression_flag_out,
           slots_used_out, inc_tb_ptr, last_vector_out
  );

  modport master (
    output valid_in, vector_in, ready_in,
    input  ready_out, valid_out, vector_out, compression_flag_out,
           slots_used_out, inc_tb_ptr, last_vector_out
  );
endinterface

// File: rtl/delta_packer.sv
// delta_packer -- packs small lane deltas between consecutive accepted
// vectors into trace-buffer entries; emits the raw vector when any lane
// delta does not fit a signed DATA_WIDTH/DELTA_SLOTS-bit field.
//
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   tracing : trace enable; a vector is accepted only while high
//   bus     : delta_packer_if.slave (input handshake, output entry
//             handshake, flag/slot count, inc_tb_ptr, reference readback)
//
// Build option: define DELTA_COMPRESSION_EN to build the packer. Without it
// the block is a one-entry raw pass-through register with the same handshake.
module delta_packer #(
  parameter int N           = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int DELTA_SLOTS = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tracing,
  delta_packer_if.slave bus
);
  localparam int SW = $clog2(DELTA_SLOTS + 1);

  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

  logic          valid_out_r, flag_r;
  vec_t          vector_out_r, last_r;
  logic [SW-1:0] slots_r;
  logic          valid_out_s, flag_s;
  vec_t          vector_out_s, last_s;
  logic [SW-1:0] slots_s;
  logic          out_free_s, ready_s, acc_s;

  // The output register can take a new entry when empty or being drained.
  assign out_free_s               = ~valid_out_r | bus.ready_in;
  assign acc_s                    = bus.valid_in & ready_s & tracing;
  assign bus.ready_out            = ready_s;
  assign bus.valid_out            = valid_out_r;
  assign bus.vector_out           = vector_out_r;
  assign bus.compression_flag_out = flag_r;
  assign bus.slots_used_out       = slots_r;
  assign bus.inc_tb_ptr           = valid_out_r & bus.ready_in;
  assign bus.last_vector_out      = last_r;

`ifdef DELTA_COMPRESSION_EN
  localparam int DW = DATA_WIDTH / DELTA_SLOTS;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PACK        = 2'd1,
    RAW_PENDING = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [SW-1:0] slot_cnt_r, slot_cnt_s;
  vec_t          pack_r, pack_s, pend_r, pend_s, pack_wr_s, delta_s;
  logic          have_ref_r, have_ref_s, tracing_d_r, compressible_s;

  // A delta fits when all bits from the field sign bit upward are equal.
  function automatic logic fits_field(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-DW:0] top;
    top = d[DATA_WIDTH-1:DW-1];
    return (top == '0) || (top == '1);
  endfunction

  assign ready_s = (state_r != RAW_PENDING) & out_free_s;

  // Lane deltas, compressibility and the pack register with the new slot written
  always_comb begin
    delta_s        = '0;
    compressible_s = have_ref_r;
    pack_wr_s      = pack_r;
    for (int i = 0; i < N; i++) begin
      delta_s[i]     = bus.vector_in[i] - last_r[i];
      compressible_s = compressible_s & fits_field(delta_s[i]);
      pack_wr_s[i][int'(slot_cnt_r)*DW +: DW] = delta_s[i][DW-1:0];
    end
  end

  // Next-state, pack/pending buffers and output entry selection
  always_comb begin
    state_s      = state_r;
    slot_cnt_s   = slot_cnt_r;
    pack_s       = pack_r;
    pend_s       = pend_r;
    have_ref_s   = have_ref_r;
    last_s       = last_r;
    valid_out_s  = valid_out_r & ~bus.ready_in;
    vector_out_s = vector_out_r;
    flag_s       = flag_r;
    slots_s      = slots_r;
    case (state_r)
      IDLE, PACK: begin
        if (acc_s) begin
          last_s     = bus.vector_in;
          have_ref_s = 1'b1;
          if (compressible_s && (slot_cnt_r == SW'(DELTA_SLOTS - 1))) begin
            // last free slot filled: emit the full pack
            valid_out_s  = 1'b1;
            vector_out_s = pack_wr_s;
            flag_s       = 1'b1;
            slots_s      = SW'(DELTA_SLOTS);
            pack_s       = '0;
            slot_cnt_s   = '0;
            state_s      = IDLE;
          end else if (compressible_s) begin
            pack_s     = pack_wr_s;
            slot_cnt_s = slot_cnt_r + SW'(1);
            state_s    = PACK;
          end else if (state_r == PACK) begin
            // flush the partial pack now, park the raw vector behind it
            valid_out_s  = 1'b1;
            vector_out_s = pack_r;
            flag_s       = 1'b1;
            slots_s      = slot_cnt_r;
            pend_s       = bus.vector_in;
            pack_s       = '0;
            slot_cnt_s   = '0;
            state_s      = RAW_PENDING;
          end else begin
            valid_out_s  = 1'b1;
            vector_out_s = bus.vector_in;
            flag_s       = 1'b0;
            slots_s      = '0;
          end
        end else if ((state_r == PACK) && !tracing && out_free_s) begin
          // tracing dropped with a partial pack: flush it once
          valid_out_s  = 1'b1;
          vector_out_s = pack_r;
          flag_s       = 1'b1;
          slots_s      = slot_cnt_r;
          pack_s       = '0;
          slot_cnt_s   = '0;
          state_s      = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      RAW_PENDING: begin
        if (out_free_s) begin
          valid_out_s  = 1'b1;
          vector_out_s = pend_r;
          flag_s       = 1'b0;
          slots_s      = '0;
          state_s      = IDLE;
        end else begin
          state_s = RAW_PENDING;
        end
      end
      default: begin
        state_s    = IDLE;
        slot_cnt_s = '0;
        pack_s     = '0;
      end
    endcase
    // a new trace session must not delta against the previous session
    if (tracing_d_r && !tracing) begin
      have_ref_s = 1'b0;
    end else begin
      have_ref_s = have_ref_s;
    end
  end

  // Packer state, pack/pending buffers and reference-valid tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      slot_cnt_r  <= '0;
      pack_r      <= '0;
      pend_r      <= '0;
      have_ref_r  <= 1'b0;
      tracing_d_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      slot_cnt_r  <= slot_cnt_s;
      pack_r      <= pack_s;
      pend_r      <= pend_s;
      have_ref_r  <= have_ref_s;
      tracing_d_r <= tracing;
    end
  end
`else
  assign ready_s = out_free_s;

  // Pass-through: every accepted vector is re-emitted raw one cycle later
  always_comb begin
    valid_out_s  = valid_out_r & ~bus.ready_in;
    vector_out_s = vector_out_r;
    last_s       = last_r;
    flag_s       = 1'b0;
    slots_s      = '0;
    if (acc_s) begin
      valid_out_s  = 1'b1;
      vector_out_s = bus.vector_in;
      last_s       = bus.vector_in;
    end else begin
      last_s = last_r;
    end
  end
`endif

  // Registered output entry and reference vector
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out_r  <= 1'b0;
      vector_out_r <= '0;
      flag_r       <= 1'b0;
      slots_r      <= '0;
      last_r       <= '0;
    end else begin
      valid_out_r  <= valid_out_s;
      vector_out_r <= vector_out_s;
      flag_r       <= flag_s;
      slots_r      <= slots_s;
      last_r       <= last_s;
    end
  end
endmodule

// File: doc/delta_packer.md
# delta_packer

Parametrised successor to the delta compressor, sitting between the filter/vector datapath and the trace buffer. It compares each accepted N-lane vector against the previously accepted one. When every lane delta fits in a signed `DATA_WIDTH/DELTA_SLOTS`-bit field, it packs up to `DELTA_SLOTS` delta vectors into a single trace-buffer entry; otherwise it emits the raw vector. It adds what the earlier block lacks: valid/ready backpressure toward the trace buffer, partial-pack flushing with an explicit slot count, and a synchronous reset.

## Interface
- `N`, 8, number of lanes.
- `DATA_WIDTH`, 8, bits per lane; must be divisible by `DELTA_SLOTS`.
- `DELTA_SLOTS`, 2, delta vectors per packed entry (≥2); localparam `DW = DATA_WIDTH/DELTA_SLOTS`, `SW = $clog2(DELTA_SLOTS+1)`.
- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tracing`  in  1  trace enable from the reconfig unit.
- `valid_in`  in  1  input vector valid.
- `ready_out`  out  1  block can accept `vector_in` this cycle.
- `vector_in`  in  `[DATA_WIDTH-1:0] x N`  input vector.
- `valid_out`  out  1  output entry valid.
- `ready_in`  in  1  trace buffer accepts the entry.
- `vector_out`  out  `[DATA_WIDTH-1:0] x N`  raw or packed entry.
- `compression_flag_out`  out  1  1 = packed entry.
- `slots_used_out`  out  `SW`  valid delta slots in a packed entry; 0 for raw.
- `inc_tb_ptr`  out  1  equals `valid_out & ready_in`.
- `last_vector_out`  out  `[DATA_WIDTH-1:0] x N`  current reference vector, for readback.

## Operation
- **Accept:** `acc = valid_in & ready_out & tracing`. While `tracing` is low, no vectors are accepted and `ready_out` is still reported.
- **Delta:** per lane, `d_i = vector_in[i] - last[i]` mod 2^DATA_WIDTH, interpreted as two's complement.
- **Compressible:** the vector is compressible if `have_ref` is set and every `d_i` lies in [-2^(DW-1), 2^(DW-1)-1].
- **Reference update:** every accepted vector updates `last` and sets `have_ref`.
- **Packing layout:** lane i, slot s occupies `vector_out[i][s*DW +: DW]`. Unused slots are 0.
- **States:**
  - IDLE: `slot_cnt` = 0.
  - PACK: 0 < `slot_cnt` < `DELTA_SLOTS`.
  - RAW_PENDING: a raw vector is held behind a flushed partial pack.
- **Compressible accept:** write the deltas into slot `slot_cnt` and increment. When `slot_cnt` reaches `DELTA_SLOTS`, load the output register (flag 1, slots = `DELTA_SLOTS`), clear the pack register and return to IDLE.
- **Incompressible accept in IDLE:** load the raw vector into the output register (flag 0, slots 0).
- **Incompressible accept in PACK:**
  - Load the partial pack into the output register (flag 1, slots = `slot_cnt`).
  - Hold the raw vector in the pending register and move to RAW_PENDING; `ready_out` = 0 while in that state.
  - Once the partial pack transfers, load the raw vector and go to IDLE.
- **Tracing fall:** when `tracing` goes 1→0 in PACK, flush the partial pack once (flag 1, slots = `slot_cnt`) and clear `have_ref`. A tracing rise therefore always starts with a raw entry.
- **ready_out:** `ready_out = (state != RAW_PENDING) & (~valid_out | ready_in)`.
- **Reset:**
  - All outputs are 0: `valid_out`, `vector_out`, flag, slots, `inc_tb_ptr`, `last_vector_out`.
  - `ready_out` = 1.
  - State IDLE, `have_ref` = 0.
  - Reset mid-pack discards the partial pack.

## Timing
- All outputs are registered except `ready_out` and `inc_tb_ptr` (combinational).
- Raw entry: `valid_out` rises 1 cycle after the accepting edge.
- Full pack: `valid_out` rises 1 cycle after the accept of the final slot.
- Partial flush then raw: the partial entry appears 1 cycle after the incompressible accept. The raw entry appears the cycle after the partial entry transfers, so a minimum of 2 consecutive `valid_out` cycles.
- Backpressure: with `valid_out` = 1 and `ready_in` = 0, `vector_out`, the flag and slots stay stable and `ready_out` = 0. No entry is lost or duplicated.
- Simultaneous tracing fall and accept: no accept occurs (`acc` needs `tracing`); the flush proceeds.
- `last_vector_out` updates on the edge of each accept.

## Configuration
- **`DELTA_COMPRESSION_EN` defined:** behaviour as above.
- **`DELTA_COMPRESSION_EN` undefined:**
  - Pass-through register with the same handshake: every accepted vector is emitted raw 1 cycle later.
  - `compression_flag_out` = 0 and `slots_used_out` = 0 always.
  - The pack and pending registers and the RAW_PENDING state are not built.
  - `last_vector_out` is still maintained.

## Test plan
All scenarios use N=8, DATA_WIDTH=8, DELTA_SLOTS=2 (DW=4), `ready_in` = 1 unless stated.
- **Full pack:** reset, `tracing` = 1, then accept {1..8}, {2..9}, {3..10} → raw {1..8} (flag 0, slots 0), then one entry with every lane 0x11 (flag 1, slots 2). `last_vector_out` = {3..10}.
- **Partial flush then raw:** accept {1..8}, {2..9}, then lane 0 = 176 (from 110000 truncated) with other lanes +1 → partial entry (lanes 0x01, flag 1, slots 1), then raw entry with lane 0 = 176 the next cycle. `ready_out` = 0 for exactly 1 cycle.
- **Signed-range edges:** reference lane 10, then 2 (d = -8) → compressible, field 0x8. Reference 10, then 1 (d = -9) → raw. d = +7 packs; d = +8 → raw.
- **Backpressure:** hold `ready_in` = 0 for 3 cycles while `valid_out` = 1 → outputs stable, `ready_out` = 0, `inc_tb_ptr` = 0. On release, exactly 1 `inc_tb_ptr` pulse per entry and no loss across 16 vectors.
- **Tracing fall mid-pack:** drop `tracing` with `slot_cnt` = 1 → one flushed entry (slots 1, flag 1). Raise `tracing` and accept {5..12} → raw entry.
- **Reset mid-pack, and compile-out:**
  - Assert `rst` with `slot_cnt` = 1 → all outputs 0 and no flush. The next accept emits raw.
  - Rerun the full-pack scenario without `DELTA_COMPRESSION_EN` → 3 raw entries, flag always 0.
